// File: rtl/uart_loader.sv
// uart_loader: serial command loader that halts a 6809 and performs single-byte memory reads/writes.
module uart_loader #(
    parameter int CLOCK_DIVISOR = 4618,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_UART_TX,
    output logic        o_UART_RX,
    output logic        o_HALT,
    input  logic        i_BA,
    output logic [15:0] o_address,
    output logic [7:0]  o_data,
    input  logic [7:0]  i_data,
    output logic        o_RW,
    output logic        o_mem_ce,
    output logic        o_error
);
    localparam int CW = $clog2(CLOCK_DIVISOR);
    localparam int TW = $clog2(TIMEOUT_BITS * CLOCK_DIVISOR);
    localparam logic [CW-1:0] BIT_END  = CW'(CLOCK_DIVISOR - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLOCK_DIVISOR / 2 - 1);
    localparam logic [TW-1:0] TMO_END  = TW'(TIMEOUT_BITS * CLOCK_DIVISOR - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [3:0] CMD_IDLE    = 4'd0;
    localparam logic [3:0] GET_AH      = 4'd1;
    localparam logic [3:0] GET_AL      = 4'd2;
    localparam logic [3:0] GET_DATA    = 4'd3;
    localparam logic [3:0] BUS_REQ     = 4'd4;
    localparam logic [3:0] BUS_STROBE  = 4'd5;
    localparam logic [3:0] BUS_CAPTURE = 4'd6;
    localparam logic [3:0] SEND_REPLY  = 4'd7;
    localparam logic [3:0] WAIT_TX     = 4'd8;

    logic          rx_s1, rx_s2, rx_s3;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_done, rx_ferr;

    logic          tx_busy;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bits;
    logic [9:0]    tx_shift;
    logic          tx_start;

    logic [3:0]    state;
    logic          op_write;
    logic [15:0]   address;
    logic [7:0]    data;
    logic [7:0]    reply;
    logic [TW-1:0] tmo;
    logic          bus;

    assign bus       = state == BUS_REQ || state == BUS_STROBE || state == BUS_CAPTURE;
    assign tx_start  = state == SEND_REPLY;
    assign o_HALT    = !bus;
    assign o_mem_ce  = state == BUS_STROBE;
    assign o_RW      = !(bus && op_write);
    assign o_address = address;
    assign o_data    = data;
    // Line is forced idle while reset is held, without waiting for a clock edge.
    assign o_UART_RX = !reset || tx_shift[0];

    // Receiver: synchronise, centre on the start bit, shift in 8N1 and flag good/bad stop bit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_done  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_s1   <= i_UART_TX;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            rx_done <= 1'b0;
            rx_ferr <= 1'b0;
            if (rx_state == RX_IDLE) begin
                if (rx_s3 && !rx_s2) begin
                    rx_state <= RX_START;
                    rx_cnt   <= HALF_END;
                end
            end else if (rx_cnt != '0) begin
                rx_cnt <= rx_cnt - 1'b1;
            end else begin
                rx_cnt <= BIT_END;
                case (rx_state)
                    RX_START: begin
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                        rx_bit   <= '0;
                    end
                    RX_DATA: begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else rx_bit <= rx_bit + 1'b1;
                    end
                    default: begin
                        rx_state <= RX_IDLE;
                        rx_done  <= rx_s2;
                        rx_ferr  <= !rx_s2;
                    end
                endcase
            end
        end
    end

    // Transmitter: shift out start, 8 data bits LSB first and stop, refilling with idle-high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bits  <= '0;
            tx_shift <= '1;
        end else if (tx_start) begin
            tx_busy  <= 1'b1;
            tx_shift <= {1'b1, reply, 1'b0};
            tx_cnt   <= BIT_END;
            tx_bits  <= 4'd9;
        end else if (tx_busy) begin
            if (tx_cnt != '0) begin
                tx_cnt <= tx_cnt - 1'b1;
            end else if (tx_bits == '0) begin
                tx_busy <= 1'b0;
            end else begin
                tx_shift <= {1'b1, tx_shift[9:1]};
                tx_bits  <= tx_bits - 1'b1;
                tx_cnt   <= BIT_END;
            end
        end
    end

    // Command parser: collect command bytes, run the halted bus access, then send the reply.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= CMD_IDLE;
            op_write <= 1'b0;
            address  <= '0;
            data     <= '0;
            reply    <= '0;
            tmo      <= '0;
            o_error  <= 1'b0;
        end else begin
            o_error <= rx_ferr;
            case (state)
                CMD_IDLE: begin
                    tmo <= '0;
                    if (rx_done) begin
                        op_write <= rx_byte_is(8'h57);
                        if (rx_byte_is(8'h57) || rx_byte_is(8'h52)) begin
                            state <= GET_AH;
                        end else begin
                            reply   <= 8'h3F;
                            o_error <= 1'b1;
                            state   <= SEND_REPLY;
                        end
                    end
                end
                GET_AH, GET_AL, GET_DATA: begin
                    if (rx_ferr) begin
                        state <= CMD_IDLE;
                    end else if (rx_done) begin
                        tmo <= '0;
                        if (state == GET_AH) begin
                            address[15:8] <= rx_shift;
                            state         <= GET_AL;
                        end else if (state == GET_AL) begin
                            address[7:0] <= rx_shift;
                            state        <= op_write ? GET_DATA : BUS_REQ;
                        end else begin
                            data  <= rx_shift;
                            state <= BUS_REQ;
                        end
                    end else if (tmo == TMO_END) begin
                        state   <= CMD_IDLE;
                        o_error <= 1'b1;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                BUS_REQ:     if (i_BA) state <= BUS_STROBE;
                BUS_STROBE:  state <= BUS_CAPTURE;
                BUS_CAPTURE: begin
                    reply <= op_write ? 8'h2E : i_data;
                    state <= SEND_REPLY;
                end
                SEND_REPLY:  state <= WAIT_TX;
                WAIT_TX:     if (!tx_busy) state <= CMD_IDLE;
                default:     state <= CMD_IDLE;
            endcase
        end
    end

    function automatic logic rx_byte_is(input logic [7:0] b);
        return rx_shift == b;
    endfunction
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: randomized scoreboard bench for uart_loader with a command-level reference model.
module tb_uart_loader;
    localparam int CD = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_UART_TX = 1'b1;
    logic        i_BA = 1'b1;
    logic [7:0]  i_data = 8'h00;
    logic        o_UART_RX, o_HALT, o_RW, o_mem_ce, o_error;
    logic [15:0] o_address;
    logic [7:0]  o_data;

    uart_loader #(.CLOCK_DIVISOR(CD), .TIMEOUT_BITS(20)) dut (
        .clk(clk), .reset(reset), .i_UART_TX(i_UART_TX), .o_UART_RX(o_UART_RX),
        .o_HALT(o_HALT), .i_BA(i_BA), .o_address(o_address), .o_data(o_data),
        .i_data(i_data), .o_RW(o_RW), .o_mem_ce(o_mem_ce), .o_error(o_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  d;
    } acc_t;

    int compared = 0;
    int mismatched = 0;
    int err_seen = 0;
    int err_exp = 0;
    int ce_count = 0;
    acc_t bus_q[$];
    logic [7:0] reply_q[$];
    logic [7:0] ref_mem[int];
    logic [7:0] mem[0:65535];
    bit written[0:65535];
    acc_t got;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory attached to the bus: data appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (o_mem_ce) begin
            if (o_RW) i_data <= written[o_address] ? mem[o_address] : init_val(o_address);
            else begin
                mem[o_address]     <= o_data;
                written[o_address] <= 1'b1;
            end
        end
    end

    // Bus monitor: every strobe must match the next expected access.
    always @(negedge clk) begin
        if (reset && o_mem_ce) begin
            ce_count++;
            check("ba_at_strobe", int'(i_BA), 1);
            check("halt_at_strobe", int'(o_HALT), 0);
            if (bus_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_strobe: got addr %h expected none", o_address);
            end else begin
                got = bus_q.pop_front();
                check("addr", int'(o_address), int'(got.a));
                check("rw", int'(o_RW), int'(got.rw));
                if (!got.rw) check("wdata", int'(o_data), int'(got.d));
            end
        end
    end

    always @(negedge clk) if (reset && o_error) err_seen++;

    // Serial monitor: decode 8N1 frames from the DUT and compare with the expected replies.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (reset && !o_UART_RX) begin
                repeat (CD / 2) @(negedge clk);
                check("reply_start", int'(o_UART_RX), 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CD) @(negedge clk);
                    b[i] = o_UART_RX;
                end
                repeat (CD) @(negedge clk);
                check("reply_stop", int'(o_UART_RX), 1);
                if (reply_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_reply: got %h expected none", b);
                end else check("reply", int'(b), int'(reply_q.pop_front()));
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    task automatic send_frame(input logic [7:0] b, input bit stop);
        @(negedge clk) i_UART_TX = 1'b0;
        repeat (CD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_UART_TX = b[i];
            repeat (CD) @(negedge clk);
        end
        i_UART_TX = stop;
        repeat (CD) @(negedge clk);
        i_UART_TX = 1'b1;
        if (!stop) repeat (CD) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        while ((reply_q.size() != 0 || bus_q.size() != 0) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (n >= 4000) begin
            mismatched++;
            $display("FAIL completion_timeout: got %0d replies pending expected 0", reply_q.size());
            reply_q.delete();
            bus_q.delete();
        end
        repeat (2 * CD) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        bus_q.push_back('{a, 1'b0, d});
        reply_q.push_back(8'h2E);
        ref_mem[int'(a)] = d;
        send_byte(8'h57);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(d);
        wait_done();
    endtask

    task automatic do_read(input logic [15:0] a);
        bus_q.push_back('{a, 1'b1, 8'h00});
        reply_q.push_back(ref_read(a));
        send_byte(8'h52);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        wait_done();
    endtask

    task automatic do_bad(input logic [7:0] b);
        reply_q.push_back(8'h3F);
        err_exp++;
        send_byte(b);
        wait_done();
        check("bad_cmd_error", err_seen, err_exp);
    endtask

    initial begin
        int c0;
        logic [7:0] b;
        logic [15:0] a;
        logic [15:0] last_a = 16'h0;
        repeat (4) @(negedge clk);
        check("rst_uart_rx", int'(o_UART_RX), 1);
        check("rst_halt", int'(o_HALT), 1);
        check("rst_mem_ce", int'(o_mem_ce), 0);
        check("rst_rw", int'(o_RW), 1);
        check("rst_address", int'(o_address), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_error", int'(o_error), 0);
        reset = 1'b1;
        repeat (4 * CD) @(negedge clk);

        c0 = ce_count;
        do_write(16'h1234, 8'hA5);
        check("write_one_strobe", ce_count, c0 + 1);
        do_write(16'hFFFE, 8'h3C);
        do_read(16'hFFFE);

        i_BA = 1'b0;
        c0 = ce_count;
        bus_q.push_back('{16'h0010, 1'b1, 8'h00});
        reply_q.push_back(ref_read(16'h0010));
        send_byte(8'h52);
        send_byte(8'h00);
        send_byte(8'h10);
        repeat (500) @(negedge clk);
        check("halt_held", int'(o_HALT), 0);
        check("no_strobe_without_ba", ce_count, c0);
        i_BA = 1'b1;
        wait_done();
        check("halt_released", int'(o_HALT), 1);
        check("strobe_after_ba", ce_count, c0 + 1);

        do_bad(8'h41);
        send_byte(8'h57);
        send_byte(8'h12);
        err_exp++;
        repeat (200) @(negedge clk);
        check("timeout_error", err_seen, err_exp);
        do_read(16'h0000);

        send_frame(8'h57, 1'b0);
        err_exp++;
        repeat (4 * CD) @(negedge clk);
        check("framing_error", err_seen, err_exp);
        @(negedge clk) i_UART_TX = 1'b0;
        repeat (3) @(negedge clk);
        i_UART_TX = 1'b1;
        repeat (250) @(negedge clk);
        check("glitch_no_error", err_seen, err_exp);
        do_write(16'h4242, 8'h99);

        i_BA = 1'b0;
        send_byte(8'h52);
        send_byte(8'h12);
        send_byte(8'h34);
        repeat (3) @(negedge clk);
        check("bus_req_halt", int'(o_HALT), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_halt", int'(o_HALT), 1);
        check("mid_rst_uart_rx", int'(o_UART_RX), 1);
        check("mid_rst_mem_ce", int'(o_mem_ce), 0);
        check("mid_rst_rw", int'(o_RW), 1);
        check("mid_rst_address", int'(o_address), 0);
        @(negedge clk) reset = 1'b1;
        i_BA = 1'b1;
        repeat (2 * CD) @(negedge clk);
        do_write(16'hBEEF, 8'h77);
        do_read(16'hBEEF);

        for (int k = 0; k < 40; k++) begin
            int r;
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 2) == 0) ? last_a : 16'($urandom);
            if (r < 4) begin
                do_write(a, 8'($urandom));
                last_a = a;
            end else if (r < 8) do_read(a);
            else begin
                do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
                do_bad(b);
            end
        end

        check("final_error_count", err_seen, err_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
